// File: rtl/warp_fetch_sequencer.sv
// warp_fetch_sequencer: walks a 32-bit warp fetch mask in ascending warp-id
// order, fetches one instruction per set bit from instruction memory using a
// per-warp PC table, and streams (warp id, instruction) beats to the decoder.
// Optional build macro KIANA_FETCH_ERR_CHECK_EN enables the err pulse
// (all-zero mask accepted, or redirect of the warp currently in flight).
module warp_fetch_sequencer #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_tvalid_ib,
    output logic        s_tready_ib,
    input  logic [31:0] fetch_mask,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        m_tvalid_dec,
    input  logic        m_tready_dec,
    output logic        m_tlast_dec,
    output logic [4:0]  m_warp_id_dec,
    output logic [31:0] m_instr_dec,
    input  logic        pc_wr_valid,
    input  logic [4:0]  pc_wr_warp,
    input  logic [31:0] pc_wr_addr,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, SEND} state_t;

    state_t      state;
    logic [31:0] pending;
    logic [4:0]  cur;
    logic [31:0] pc_tbl [32];

    logic [31:0] pend_clr;
    logic [4:0]  first_idx;
    logic [4:0]  next_idx;
    logic [31:0] first_addr;
    logic [31:0] next_addr;
    logic        accept;
    logic        send_hs;

    function automatic logic [4:0] lowest(input logic [31:0] m);
        lowest = '0;
        for (int i = 31; i >= 0; i--)
            if (m[i]) lowest = 5'(i);
    endfunction

    // Next-warp selection; a redirect landing in the same cycle is forwarded
    // so the issued address always reflects the newest PC.
    always_comb begin
        pend_clr   = pending & ~(32'd1 << cur);
        first_idx  = lowest(fetch_mask);
        next_idx   = lowest(pend_clr);
        first_addr = (pc_wr_valid && pc_wr_warp == first_idx) ? pc_wr_addr : pc_tbl[first_idx];
        next_addr  = (pc_wr_valid && pc_wr_warp == next_idx)  ? pc_wr_addr : pc_tbl[next_idx];
        accept     = (state == IDLE) && s_tvalid_ib && s_tready_ib;
        send_hs    = (state == SEND) && m_tvalid_dec && m_tready_dec;
    end

    // Sequencing FSM; every output is a register so m_tvalid_dec never
    // depends combinationally on m_tready_dec.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pending        <= '0;
            cur            <= '0;
            s_tready_ib    <= 1'b0;
            imem_req_valid <= 1'b0;
            imem_addr      <= '0;
            m_tvalid_dec   <= 1'b0;
            m_tlast_dec    <= 1'b0;
            m_warp_id_dec  <= '0;
            m_instr_dec    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    s_tready_ib <= 1'b1;
                    if (accept) begin
                        pending <= fetch_mask;
                        if (fetch_mask != '0) begin
                            cur            <= first_idx;
                            imem_addr      <= first_addr;
                            imem_req_valid <= 1'b1;
                            s_tready_ib    <= 1'b0;
                            state          <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        m_instr_dec   <= imem_rsp_data;
                        m_warp_id_dec <= cur;
                        m_tlast_dec   <= (pend_clr == '0);
                        m_tvalid_dec  <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (send_hs) begin
                        pending      <= pend_clr;
                        m_tvalid_dec <= 1'b0;
                        m_tlast_dec  <= 1'b0;
                        if (pend_clr != '0) begin
                            cur            <= next_idx;
                            imem_addr      <= next_addr;
                            imem_req_valid <= 1'b1;
                            state          <= REQ;
                        end else begin
                            s_tready_ib <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // PC table: post-increment on handshake; a redirect to the same warp
    // is written last so it overrides the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                pc_tbl[i] <= PC_RESET;
        end else begin
            if (send_hs)
                pc_tbl[cur] <= pc_tbl[cur] + 32'd4;
            if (pc_wr_valid)
                pc_tbl[pc_wr_warp] <= pc_wr_addr;
        end
    end

`ifdef KIANA_FETCH_ERR_CHECK_EN
    // One-cycle error pulse for empty masks and redirects of the in-flight warp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else
            err <= (accept && fetch_mask == '0) ||
                   (state != IDLE && pc_wr_valid && pc_wr_warp == cur);
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_warp_fetch_sequencer.sv
// Scoreboard bench for warp_fetch_sequencer: stimulus pushes expected beats,
// a monitor pops and compares them, a memory agent serves imem requests.
module tb_warp_fetch_sequencer;

    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        s_tvalid_ib;
    logic        s_tready_ib;
    logic [31:0] fetch_mask;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        m_tvalid_dec;
    logic        m_tready_dec;
    logic        m_tlast_dec;
    logic [4:0]  m_warp_id_dec;
    logic [31:0] m_instr_dec;
    logic        pc_wr_valid;
    logic [4:0]  pc_wr_warp;
    logic [31:0] pc_wr_addr;
    logic        err;

    warp_fetch_sequencer #(.PC_RESET(PC_RESET)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid_ib(s_tvalid_ib), .s_tready_ib(s_tready_ib), .fetch_mask(fetch_mask),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .m_tvalid_dec(m_tvalid_dec), .m_tready_dec(m_tready_dec), .m_tlast_dec(m_tlast_dec),
        .m_warp_id_dec(m_warp_id_dec), .m_instr_dec(m_instr_dec),
        .pc_wr_valid(pc_wr_valid), .pc_wr_warp(pc_wr_warp), .pc_wr_addr(pc_wr_addr),
        .err(err)
    );

    typedef struct packed {
        logic [4:0]  w;
        logic [31:0] instr;
        logic        last;
    } beat_t;

    beat_t       q[$];
    logic [31:0] exp_pc [32];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          err_cnt = 0;
    int          exp_err = 0;
    int          req_cnt = 0;
    int          req_stall = 0;
    int          rsp_delay = 0;
    bit          spurious = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content is a fixed function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout", name);
    endfunction

    // Instruction memory agent, driven on the falling edge.
    initial begin : mem_agent
        bit          seen;
        int          wait_cnt;
        int          rsp_cnt;
        logic [31:0] first_addr;
        logic [31:0] lat_addr;
        seen = 0; wait_cnt = 0; rsp_cnt = 0; first_addr = '0; lat_addr = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = memf(lat_addr);
                end
            end
            if (!rst_n) begin
                seen = 0;
            end else if (imem_req_valid) begin
                if (!seen) begin
                    seen = 1; first_addr = imem_addr; wait_cnt = 0;
                end else begin
                    chk("imem_addr_stable", imem_addr, first_addr);
                end
                if (wait_cnt >= req_stall) begin
                    imem_req_ready = 1'b1;
                    lat_addr = imem_addr;
                    rsp_cnt = rsp_delay + 1;
                    seen = 0;
                    req_cnt++;
                end else begin
                    if (spurious && wait_cnt == 1) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = 32'hDEAD_BEEF;
                    end
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: compares every presented beat (held or accepted) with the queue head.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (err === 1'b1) err_cnt++;
            if (m_tvalid_dec === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: warp %0d instr %h", m_warp_id_dec, m_instr_dec);
                end else begin
                    chk("beat_warp",  32'(m_warp_id_dec), 32'(q[0].w));
                    chk("beat_instr", m_instr_dec,        q[0].instr);
                    chk("beat_last",  32'(m_tlast_dec),   32'(q[0].last));
                    if (m_tready_dec) void'(q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [31:0] mask);
        int t = 0;
        @(negedge clk);
        while (!s_tready_ib && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!s_tready_ib) timeout("issue_ready");
        s_tvalid_ib = 1'b1;
        fetch_mask  = mask;
        for (int i = 0; i < 32; i++) begin
            if (mask[i]) begin
                q.push_back(beat_t'{w: 5'(i), instr: memf(exp_pc[i]), last: ((mask >> (i + 1)) == 32'd0)});
                exp_pc[i] = exp_pc[i] + 32'd4;
            end
        end
        @(negedge clk);
        s_tvalid_ib = 1'b0;
        fetch_mask  = '0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((q.size() != 0 || !s_tready_ib) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0 || !s_tready_ib) timeout(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_tvalid(input string name);
        int t = 0;
        while (!m_tvalid_dec && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!m_tvalid_dec) timeout(name);
    endtask

    initial begin : stim
        int r0;
        int t;
        rst_n = 1'b1;
        s_tvalid_ib = 1'b0; fetch_mask = '0; m_tready_dec = 1'b1;
        pc_wr_valid = 1'b0; pc_wr_warp = '0; pc_wr_addr = '0;
        for (int i = 0; i < 32; i++) exp_pc[i] = PC_RESET;
        #2 rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tready",   32'(s_tready_ib),    32'd0);
        chk("rst_req_vld",  32'(imem_req_valid), 32'd0);
        chk("rst_tvalid",   32'(m_tvalid_dec),   32'd0);
        chk("rst_tlast",    32'(m_tlast_dec),    32'd0);
        chk("rst_warp",     32'(m_warp_id_dec),  32'd0);
        chk("rst_instr",    m_instr_dec,         32'd0);
        chk("rst_err",      32'(err),            32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("tready_after_rst", 32'(s_tready_ib), 32'd1);

        // Two warps, zero-wait memory; repeat to confirm both PCs advanced
        issue(32'h0000_0005);
        wait_idle("mask5_a");
        issue(32'h0000_0005);
        wait_idle("mask5_b");

        // Warp 31 held under backpressure for 5 cycles
        m_tready_dec = 1'b0;
        issue(32'h8000_0000);
        wait_tvalid("w31_tvalid");
        repeat (5) @(negedge clk);
        m_tready_dec = 1'b1;
        wait_idle("w31_a");
        issue(32'h8000_0000);
        wait_idle("w31_b");

        // Redirect coinciding with the handshake of the same warp
        m_tready_dec = 1'b0;
        issue(32'h0000_0008);
        wait_tvalid("w3_tvalid");
        m_tready_dec = 1'b1;
        pc_wr_valid = 1'b1; pc_wr_warp = 5'd3; pc_wr_addr = 32'h0000_0100;
`ifdef KIANA_FETCH_ERR_CHECK_EN
        exp_err++;
`endif
        @(negedge clk);
        pc_wr_valid = 1'b0;
        exp_pc[3] = 32'h0000_0100;
        wait_idle("w3_a");
        issue(32'h0000_0008);
        wait_idle("w3_b");

        // Slow memory: stalled request, late response, spurious response in REQ
        req_stall = 4; rsp_delay = 6; spurious = 1;
        r0 = req_cnt;
        issue(32'h0000_0010);
        wait_idle("slow_mem");
        chk("one_request", 32'(req_cnt - r0), 32'd1);
        req_stall = 0; rsp_delay = 0; spurious = 0;

        // Empty mask: no beats, back to IDLE
        issue(32'h0000_0000);
`ifdef KIANA_FETCH_ERR_CHECK_EN
        exp_err++;
`endif
        wait_idle("mask0");
        chk("mask0_tready", 32'(s_tready_ib), 32'd1);

        // Reset while waiting on memory inside a three-warp sequence
        rsp_delay = 6;
        r0 = req_cnt;
        issue(32'h0000_0007);
        t = 0;
        while (req_cnt == r0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (req_cnt == r0) timeout("mid_req");
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        for (int i = 0; i < 32; i++) exp_pc[i] = PC_RESET;
        @(negedge clk);
        chk("midrst_tready", 32'(s_tready_ib),    32'd0);
        chk("midrst_tvalid", 32'(m_tvalid_dec),   32'd0);
        chk("midrst_reqvld", 32'(imem_req_valid), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_tready_after", 32'(s_tready_ib), 32'd1);
        rsp_delay = 0;
        issue(32'h0000_0007);
        wait_idle("after_rst");

        chk("err_pulses",  32'(err_cnt),  32'(exp_err));
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
